// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the HI/LO pair; one shift step per cycle, fixed latency.
// Define MDU_DIV_EN to include the restoring divider (div/divu); without it only mult/multu/mthi/mtlo exist.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               neg_q_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] result;

`ifdef MDU_DIV_EN
  logic               is_div_reg;
  logic               neg_r_reg;
  logic               dz_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  // Signed ops (even opcodes) work on magnitudes; signs are reapplied in FIX.
  assign sa    = ~op[0] & a[WIDTH-1];
  assign sb    = ~op[0] & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  // Multiply: work_reg = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} +
                    (work_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, work_reg[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  // Divide: work_reg = {partial remainder, dividend bits becoming quotient bits}.
  assign div_shift = work_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};

  always_comb begin
    if (!div_diff[WIDTH]) begin
      div_step = {div_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {div_shift[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign work_next = is_div_reg ? div_step : mul_step;
`else
  assign work_next = mul_step;
`endif

  always_comb begin
    result = neg_q_reg ? -work_reg : work_reg;
`ifdef MDU_DIV_EN
    quo_fix = neg_q_reg ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];
    rem_fix = neg_r_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];
    if (is_div_reg) begin
      // Divide by zero: quotient all ones, remainder is the raw dividend.
      result = dz_reg ? {a_reg, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      work_reg   <= '0;
      opnd_reg   <= '0;
      neg_q_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
`ifdef MDU_DIV_EN
      is_div_reg <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      a_reg      <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                work_reg   <= {{WIDTH{1'b0}}, abs_b};
                opnd_reg   <= abs_a;
                neg_q_reg  <= sa ^ sb;
                cnt_reg    <= '0;
                busy_reg   <= 1'b1;
                state_reg  <= RUN;
`ifdef MDU_DIV_EN
                is_div_reg <= 1'b0;
`endif
              end
`ifdef MDU_DIV_EN
              3'b010, 3'b011: begin
                work_reg   <= {{WIDTH{1'b0}}, abs_a};
                opnd_reg   <= abs_b;
                neg_q_reg  <= sa ^ sb;
                neg_r_reg  <= sa;
                dz_reg     <= (b == '0);
                a_reg      <= a;
                is_div_reg <= 1'b1;
                cnt_reg    <= '0;
                busy_reg   <= 1'b1;
                state_reg  <= RUN;
              end
`endif
              3'b100:  hi_reg <= a;
              3'b101:  lo_reg <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          work_reg <= work_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            busy_reg  <= 1'b0;
            state_reg <= FIX;
          end
        end
        FIX: begin
          hi_reg    <= result[2*WIDTH-1:WIDTH];
          lo_reg    <= result[WIDTH-1:0];
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized bench for mdu_hilo against a plain-arithmetic HI/LO reference model.
module tb_mdu_hilo;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one request, from integer arithmetic.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] eh, output logic [31:0] el);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    eh = m_hi;
    el = m_lo;
    case (o)
      3'b000: begin sp = sx * sy; eh = sp[63:32]; el = sp[31:0]; end
      3'b001: begin up = ux * uy; eh = up[63:32]; el = up[31:0]; end
      3'b010, 3'b011: begin
        if (DIV_EN) begin
          if (y == 32'd0) begin
            el = 32'hFFFF_FFFF; eh = x;
          end else if (o == 3'b010) begin
            sp = sx / sy; el = sp[31:0];
            sp = sx % sy; eh = sp[31:0];
          end else begin
            el = x / y; eh = x % y;
          end
        end
      end
      3'b100: eh = x;
      3'b101: el = x;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int intr_at, input int rst_at);
    logic [31:0] eh, el;
    logic        long_op;
    int          busy_cnt, done_cnt, done_edge;
    long_op = (o == 3'b000) || (o == 3'b001) || (DIV_EN && (o == 3'b010 || o == 3'b011));
    ref_model(o, x, y, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    if (!long_op) begin
      check_eq("short_busy", 64'(busy), 64'(0));
      check_eq("short_done", 64'(done), 64'(0));
      check_eq("short_hi", 64'(hi), 64'(eh));
      check_eq("short_lo", 64'(lo), 64'(el));
      m_hi = eh; m_lo = el;
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h (short)", o, x, y, hi, lo);
    end else begin
      busy_cnt = 0; done_cnt = 0; done_edge = -1;
      for (int i = 0; i <= 36; i++) begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          if (done_edge < 0) done_edge = i;
        end
        if (i == 32) begin
          check_eq("hold_hi", 64'(hi), 64'(m_hi));
          check_eq("hold_lo", 64'(lo), 64'(m_lo));
        end
        if (i == intr_at) begin
          start = 1'b1; op = 3'b100; a = 32'h55;
        end
        if (i == rst_at) begin
          rst = 1'b1; #2; rst = 1'b0;
          m_hi = '0; m_lo = '0;
          eh = '0; el = '0;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (rst_at >= 0) begin
        check_eq("rst_done_cnt", 64'(done_cnt), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
      end else begin
        check_eq("busy_cycles", 64'(busy_cnt), 64'(32));
        check_eq("done_edge", 64'(done_edge), 64'(33));
        check_eq("done_pulses", 64'(done_cnt), 64'(1));
      end
      check_eq("res_hi", 64'(hi), 64'(eh));
      check_eq("res_lo", 64'(lo), 64'(el));
      m_hi = eh; m_lo = el;
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h done_edge=%0d", o, x, y, hi, lo, done_edge);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy0", 64'(busy), 64'(0));
    check_eq("rst_done0", 64'(done), 64'(0));
    check_eq("rst_hi0", 64'(hi), 64'(0));
    check_eq("rst_lo0", 64'(lo), 64'(0));
    rst = 1'b0;

    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, -1, -1);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op(3'b011, 32'd7, 32'd0, -1, -1);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(3'b000, 32'd2, 32'd3, 4, -1);
    run_op(3'b000, 32'd9, 32'd9, -1, 10);
    run_op(3'b000, 32'd4, 32'd4, -1, -1);
    run_op(3'b100, 32'h1234, 32'd0, -1, -1);
    run_op(3'b101, 32'h5678, 32'd0, -1, -1);
    run_op(3'b110, 32'hDEAD_BEEF, 32'd1, -1, -1);
    run_op(3'b111, 32'hCAFE_F00D, 32'd1, -1, -1);

    for (int t = 0; t < 40; t++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
